// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
//   slave  : converter side (accepts bin_in, produces bcd_out/lz_mask/ovf)
//   master : client side (drives bin_in/in_valid, consumes the result)
// Input channel : in_valid, in_ready, bin_in[BIN_W]
// Output channel: out_valid, out_ready, bcd_out[4*DIGITS], lz_mask[DIGITS], ovf
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     lz_mask;
    logic                  ovf;

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, lz_mask, ovf
    );

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, lz_mask, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Time-shared between display fields through valid/ready handshakes; also
// produces a leading-zero blanking mask and a saturating overflow flag.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bin2bcd_seq_if.slave (in_valid/in_ready/bin_in,
//           out_valid/out_ready/bcd_out/lz_mask/ovf)
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    bin2bcd_seq_if.slave bus
);

    // Decimal digits needed to hold 2^w - 1.
    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned m;
        int unsigned     n;
        m = (64'd1 << w) - 64'd1;
        n = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam int unsigned     SCR_DIGITS = dec_digits(BIN_W);
    localparam int unsigned     SCR_W      = 4 * SCR_DIGITS;
    localparam int unsigned     OUT_W      = 4 * DIGITS;
    localparam int unsigned     CAT_W      = SCR_W + BIN_W;
    localparam int unsigned     CNT_W      = $clog2(BIN_W + 1);
    localparam longint unsigned OVF_LIMIT  = pow10(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e             state_q,     state_d;
    logic [BIN_W-1:0]   bin_q,       bin_d;
    logic [SCR_W-1:0]   scr_q,       scr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               ovf_pend_q,  ovf_pend_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   bcd_q,       bcd_d;
    logic [DIGITS-1:0]  lz_q,        lz_d;
    logic               ovf_q,       ovf_d;

    logic [SCR_W-1:0]   scr_adj;
    logic [CAT_W-1:0]   cat_sh;
    logic [SCR_W-1:0]   scr_shift;
    logic [BIN_W-1:0]   bin_shift;
    logic [OUT_W-1:0]   res_bcd;
    logic [DIGITS-1:0]  res_lz;
    logic               seen_nz;

    // Datapath: one double-dabble step and the result formatting it would yield.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < int'(SCR_DIGITS); i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
        cat_sh    = {scr_adj, bin_q} << 1;
        scr_shift = cat_sh[CAT_W-1:BIN_W];
        bin_shift = cat_sh[BIN_W-1:0];

        // Scratch may be narrower or wider than the output; the cast pads or drops.
        res_bcd = ovf_pend_q ? {DIGITS{4'h9}} : OUT_W'(scr_shift);

        // Blank digit k only if it and every digit above it are zero; digit 0 stays lit.
        res_lz  = '0;
        seen_nz = 1'b0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            seen_nz   = seen_nz | (res_bcd[4*k +: 4] != 4'd0);
            res_lz[k] = ~seen_nz;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        scr_d       = scr_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        bcd_d       = bcd_q;
        lz_d        = lz_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    bin_d      = bus.bin_in;
                    scr_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = (64'(bus.bin_in) >= OVF_LIMIT);
                    in_ready_d = 1'b0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bin_d = bin_shift;
                scr_d = scr_shift;
                cnt_d = cnt_q - CNT_W'(1);
                // Last step: capture the result from the final shifted value.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d       = res_bcd;
                    lz_d        = res_lz;
                    ovf_d       = ovf_pend_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            scr_q       <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            lz_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            scr_q       <= scr_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            bcd_q       <= bcd_d;
            lz_q        <= lz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.lz_mask   = lz_q;
    assign bus.ovf       = ovf_q;

endmodule
